// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the memory bus arbiter: FSM states,
// grant encodings and the default access timeout.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_CPU  = 2'b01;
   localparam logic [1:0] GNT_DMA  = 2'b10;

   localparam int TIMEOUT_DEF = 15;

endpackage

// File: rtl/mem_bus_arbiter_rr2.sv
// Two-way round-robin pick. Purely combinational.
// Ports: req[0]=CPU, req[1]=DMA; last_grant; grant (one-hot or zero).
module arb_rr2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic [1:0] last_grant,
   output logic [1:0] grant
);

   always_comb begin
      grant = GNT_NONE;
      case (req)
         2'b01:   grant = GNT_CPU;
         2'b10:   grant = GNT_DMA;
         // on a tie, whoever did not win last time goes first
         2'b11:   grant = (last_grant == GNT_CPU) ? GNT_DMA : GNT_CPU;
         default: grant = GNT_NONE;
      endcase
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one memory port between CPU and DMA requesters.
// Ports: cpu_*/dma_* request ports, mem_* memory side, grant, busy.
module mem_bus_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW      = 16,
   parameter int DW      = 16,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic          clk,
   input  logic          rstIn,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_done,
   output logic          cpu_err,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic [DW-1:0] dma_rdata,
   output logic          dma_done,
   output logic          dma_err,
   output logic [AW-1:0] mem_Abus,
   inout  wire  [DW-1:0] mem_Dbus,
   output logic          mem_rdM,
   output logic          mem_wrM,
   input  logic          mem_mfc,
   output logic [1:0]    grant,
   output logic          busy
);

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t        state_q, state_n;
   logic [1:0]    grant_q, grant_n;
   logic [1:0]    last_q, last_n;
   logic [1:0]    pick;
   logic          we_q, we_n;
   logic [AW-1:0] addr_q, addr_n;
   logic [DW-1:0] wdata_q, wdata_n;
   logic [7:0]    cnt_q, cnt_n;
   logic          err_q, err_n;
   logic [DW-1:0] crd_q, crd_n;
   logic [DW-1:0] drd_q, drd_n;
   logic          acc, dn;

   arb_rr2 u_rr (
      .req        ({dma_req, cpu_req}),
      .last_grant (last_q),
      .grant      (pick)
   );

   always_ff @(posedge clk or negedge rstIn) begin
      if (!rstIn) begin
         state_q <= IDLE;
         grant_q <= GNT_NONE;
         last_q  <= GNT_DMA;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         crd_q   <= '0;
         drd_q   <= '0;
      end else begin
         state_q <= state_n;
         grant_q <= grant_n;
         last_q  <= last_n;
         we_q    <= we_n;
         addr_q  <= addr_n;
         wdata_q <= wdata_n;
         cnt_q   <= cnt_n;
         err_q   <= err_n;
         crd_q   <= crd_n;
         drd_q   <= drd_n;
      end
   end

   always_comb begin
      state_n = state_q;
      grant_n = grant_q;
      last_n  = last_q;
      we_n    = we_q;
      addr_n  = addr_q;
      wdata_n = wdata_q;
      cnt_n   = cnt_q;
      err_n   = err_q;
      crd_n   = crd_q;
      drd_n   = drd_q;
      unique case (state_q)
         IDLE: begin
            // a stale mfc from the last access blocks new grants
            if (!mem_mfc && pick != GNT_NONE) begin
               grant_n = pick;
               if (pick == GNT_CPU) begin
                  we_n    = cpu_we;
                  addr_n  = cpu_addr;
                  wdata_n = cpu_wdata;
               end else begin
                  we_n    = dma_we;
                  addr_n  = dma_addr;
                  wdata_n = dma_wdata;
               end
               cnt_n   = '0;
               err_n   = 1'b0;
               state_n = ACCESS;
            end
         end
         ACCESS: begin
            if (mem_mfc) begin
               err_n = 1'b0;
               if (!we_q) begin
                  if (grant_q == GNT_CPU) crd_n = mem_Dbus;
                  else                    drd_n = mem_Dbus;
               end
               state_n = DONE;
            end else if (cnt_q == CNT_LAST) begin
               err_n   = 1'b1;
               state_n = DONE;
            end else begin
               cnt_n = cnt_q + 8'd1;
            end
         end
         DONE: begin
            last_n  = grant_q;
            grant_n = GNT_NONE;
            state_n = IDLE;
         end
         default: begin
            grant_n = GNT_NONE;
            state_n = IDLE;
         end
      endcase
   end

   assign acc = (state_q == ACCESS);
   assign dn  = (state_q == DONE);

   assign mem_Abus = addr_q;
   assign mem_rdM  = acc & ~we_q;
   assign mem_wrM  = acc & we_q;
   assign mem_Dbus = (acc & we_q) ? wdata_q : {DW{1'bz}};

   assign cpu_rdata = crd_q;
   assign dma_rdata = drd_q;
   assign cpu_done  = dn & grant_q[0];
   assign dma_done  = dn & grant_q[1];
   assign cpu_err   = dn & grant_q[0] & err_q;
   assign dma_err   = dn & grant_q[1] & err_q;

   assign grant = grant_q;
   assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: table vectors, random transactions
// against a transaction-level model, and directed corner sequences.
module tb_mem_bus_arbiter;
   import mem_arb_pkg::*;

   localparam int TO    = 15;
   localparam int NOMFC = 255;

   logic        clk = 1'b0;
   logic        rstIn = 1'b0;
   logic        cpu_req = 0, cpu_we = 0;
   logic [15:0] cpu_addr = 0, cpu_wdata = 0;
   logic        dma_req = 0, dma_we = 0;
   logic [15:0] dma_addr = 0, dma_wdata = 0;
   logic [15:0] cpu_rdata, dma_rdata, mem_Abus;
   logic        cpu_done, cpu_err, dma_done, dma_err;
   logic        mem_rdM, mem_wrM, busy;
   logic [1:0]  grant;
   wire  [15:0] mem_Dbus;
   wire         mem_mfc;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.AW(16), .DW(16), .TIMEOUT(TO)) dut (
      .clk(clk), .rstIn(rstIn),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
      .cpu_done(cpu_done), .cpu_err(cpu_err),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
      .dma_wdata(dma_wdata), .dma_rdata(dma_rdata),
      .dma_done(dma_done), .dma_err(dma_err),
      .mem_Abus(mem_Abus), .mem_Dbus(mem_Dbus),
      .mem_rdM(mem_rdM), .mem_wrM(mem_wrM), .mem_mfc(mem_mfc),
      .grant(grant), .busy(busy)
   );

   // memory responder: parks 0 on the bus when idle, drives on reads
   logic [15:0] phys [256];
   int          rsp_dly = 0;
   logic        force_mfc = 1'b0;
   logic        auto_mfc = 1'b0;
   logic        drv_en = 1'b1;
   logic [15:0] drv_val = 16'h0;
   int          acc_cnt = 0;

   assign mem_mfc  = auto_mfc | force_mfc;
   assign mem_Dbus = drv_en ? drv_val : 16'hzzzz;

   always @(posedge clk) begin
      #1;
      if (mem_rdM || mem_wrM) begin
         auto_mfc = (rsp_dly != NOMFC) && (acc_cnt == rsp_dly);
         if (auto_mfc && mem_wrM) phys[mem_Abus[7:0]] = mem_Dbus;
         drv_en  = mem_rdM;
         drv_val = phys[mem_Abus[7:0]];
         acc_cnt++;
      end else begin
         auto_mfc = 1'b0;
         drv_en   = 1'b1;
         drv_val  = 16'h0;
         acc_cnt  = 0;
      end
   end

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   // transaction-level reference state
   logic [1:0]  m_last;
   logic [15:0] m_crd, m_drd;
   logic [15:0] ref_mem [256];

   function automatic logic [1:0] m_pick(input logic cr, input logic dr);
      if (cr && dr) return (m_last == GNT_CPU) ? GNT_DMA : GNT_CPU;
      if (cr) return GNT_CPU;
      if (dr) return GNT_DMA;
      return GNT_NONE;
   endfunction

   task automatic m_reset();
      m_last = GNT_DMA;
      m_crd  = 16'h0;
      m_drd  = 16'h0;
   endtask

   typedef struct {
      logic        cr, cw;
      logic [15:0] ca, cd;
      logic        dr, dw;
      logic [15:0] da, dd;
      int          dly;
      logic [1:0]  eg;
      logic        ee;
   } vec_t;

   // call just after a negedge with the DUT idle
   task automatic run_txn(input vec_t v);
      logic        we;
      logic [15:0] a, d;
      int          dk;
      cpu_req = v.cr; cpu_we = v.cw; cpu_addr = v.ca; cpu_wdata = v.cd;
      dma_req = v.dr; dma_we = v.dw; dma_addr = v.da; dma_wdata = v.dd;
      rsp_dly = v.dly;
      we = (v.eg == GNT_CPU) ? v.cw : v.dw;
      a  = (v.eg == GNT_CPU) ? v.ca : v.da;
      d  = (v.eg == GNT_CPU) ? v.cd : v.dd;
      dk = v.ee ? TO + 1 : v.dly + 2;
      for (int k = 1; k <= dk; k++) begin
         @(negedge clk);
         if (k < dk) begin
            chk("access", {grant, mem_rdM, mem_wrM, cpu_done, dma_done, busy},
                {v.eg, ~we, we, 1'b0, 1'b0, 1'b1});
            if (k == 1) begin
               chk("abus", mem_Abus, a);
               if (we) chk("dbus_wr", mem_Dbus, d);
            end
         end else begin
            chk("done", {grant, mem_rdM, mem_wrM, cpu_done, dma_done, busy},
                {v.eg, 1'b0, 1'b0, v.eg[0], v.eg[1], 1'b1});
            chk("err", {cpu_err, dma_err}, {v.eg[0] & v.ee, v.eg[1] & v.ee});
            if (!v.ee) begin
               if (we) ref_mem[a[7:0]] = d;
               else if (v.eg == GNT_CPU) m_crd = ref_mem[a[7:0]];
               else m_drd = ref_mem[a[7:0]];
            end
            chk("cpu_rdata", cpu_rdata, m_crd);
            chk("dma_rdata", dma_rdata, m_drd);
            chk("dbus_rel", mem_Dbus, 16'h0);
            m_last  = v.eg;
            cpu_req = 1'b0;
            dma_req = 1'b0;
         end
      end
      @(negedge clk);
      chk("idle", {grant, mem_rdM, mem_wrM, cpu_done, dma_done, busy}, 7'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstIn = 1'b0;
      cpu_req = 1'b0;
      dma_req = 1'b0;
      force_mfc = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rstIn = 1'b1;
      m_reset();
   endtask

   vec_t tbl [9];
   vec_t rv;
   logic [1:0] seq [$];
   logic [1:0] prevg;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 256; i++) begin
         phys[i]    = 16'(i * 16'h0101) ^ 16'h5a5a;
         ref_mem[i] = 16'(i * 16'h0101) ^ 16'h5a5a;
      end
      phys[8'h10]    = 16'hBEEF;
      ref_mem[8'h10] = 16'hBEEF;

      //          cr    cw    ca        cd        dr    dw    da        dd        dly    eg       ee
      tbl[0] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1,     GNT_CPU, 1'b0};
      tbl[1] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0200, 16'h1234, 0,     GNT_DMA, 1'b0};
      tbl[2] = '{1'b1, 1'b0, 16'h0200, 16'h0000, 1'b1, 1'b1, 16'h0033, 16'hA5A5, 0,     GNT_CPU, 1'b0};
      tbl[3] = '{1'b1, 1'b1, 16'h0044, 16'h7777, 1'b1, 1'b0, 16'h0033, 16'h0000, 0,     GNT_DMA, 1'b0};
      tbl[4] = '{1'b1, 1'b0, 16'h0044, 16'h0000, 1'b1, 1'b1, 16'h0045, 16'h0F0F, 2,     GNT_CPU, 1'b0};
      tbl[5] = '{1'b1, 1'b1, 16'h0046, 16'h1111, 1'b1, 1'b0, 16'h0010, 16'h0000, 3,     GNT_DMA, 1'b0};
      tbl[6] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'h0000, NOMFC, GNT_DMA, 1'b1};
      tbl[7] = '{1'b1, 1'b1, 16'h0050, 16'h9999, 1'b0, 1'b0, 16'h0000, 16'h0000, NOMFC, GNT_CPU, 1'b1};
      tbl[8] = '{1'b1, 1'b0, 16'h0050, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 0,     GNT_CPU, 1'b0};

      // reset state
      m_reset();
      @(negedge clk);
      @(negedge clk);
      chk("rst_ctrl", {grant, busy, mem_rdM, mem_wrM, cpu_done, cpu_err,
                       dma_done, dma_err}, 9'b0);
      chk("rst_rdata", {cpu_rdata, dma_rdata}, 32'h0);
      chk("rst_abus", mem_Abus, 16'h0);
      chk("rst_dbus", mem_Dbus, 16'h0);
      rstIn = 1'b1;

      // contention from reset with both requests held throughout
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0001;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0002;
      rsp_dly = 0;
      prevg = GNT_NONE;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk("not_both", {31'b0, grant == 2'b11}, 32'h0);
         if (grant != GNT_NONE && prevg == GNT_NONE) seq.push_back(grant);
         prevg = grant;
      end
      chk("rr_seq0", (seq.size() > 0) ? seq[0] : 2'b11, GNT_CPU);
      chk("rr_seq1", (seq.size() > 1) ? seq[1] : 2'b11, GNT_DMA);
      chk("rr_seq2", (seq.size() > 2) ? seq[2] : 2'b11, GNT_CPU);
      chk("rr_seq3", (seq.size() > 3) ? seq[3] : 2'b11, GNT_DMA);
      do_reset();

      // table vectors
      for (int i = 0; i < 9; i++) run_txn(tbl[i]);

      // stale mfc blocks the grant until it falls
      force_mfc = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0044;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("stale_mfc", {grant, busy, mem_rdM}, 4'b0);
      end
      force_mfc = 1'b0;
      rv = '{1'b1, 1'b0, 16'h0044, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 0, GNT_CPU, 1'b0};
      run_txn(rv);

      // random transactions against the model
      for (int i = 0; i < 40; i++) begin
         int r;
         rv.cr = 1'($urandom);
         rv.dr = 1'($urandom);
         if (!rv.cr && !rv.dr) rv.cr = 1'b1;
         rv.cw = 1'($urandom);
         rv.dw = 1'($urandom);
         rv.ca = 16'($urandom);
         rv.da = 16'($urandom);
         rv.cd = 16'($urandom) | 16'h1;
         rv.dd = 16'($urandom) | 16'h1;
         r = int'($urandom_range(0, 7));
         rv.dly = (r == 7) ? NOMFC : r % 4;
         rv.eg = m_pick(rv.cr, rv.dr);
         rv.ee = (rv.dly == NOMFC);
         run_txn(rv);
      end

      // reset in the middle of a CPU write
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0060; cpu_wdata = 16'hC3C3;
      rsp_dly = NOMFC;
      @(negedge clk);
      @(negedge clk);
      chk("mid_wr", {mem_wrM, mem_Dbus}, {1'b1, 16'hC3C3});
      #1;
      rstIn = 1'b0;
      #1;
      chk("mid_rst", {mem_wrM, mem_rdM, busy, grant, cpu_done}, 6'b0);
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0010;
      @(negedge clk);
      chk("rst_nodone", {cpu_done, cpu_err, mem_Dbus}, 18'h0);
      @(negedge clk);
      rstIn = 1'b1;
      m_reset();
      rv = '{1'b1, 1'b0, 16'h0046, 16'h0, 1'b1, 1'b0, 16'h0010, 16'h0, 0, GNT_CPU, 1'b0};
      run_txn(rv);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Arbitrates the single memory port (Abus/Dbus, rdM/wrM, mfc) between two requesters: the CPU controller and a DMA/program-loader port. Each access is latched, run to completion on mfc or abandoned on timeout, and then acknowledged with a one-cycle done pulse. The block sits between the controller/datapath and memoryModule and replaces direct controller drive of rdM/wrM.

Parameters:
AW, 16, address width (matches Abus)
DW, 16, data width (matches Dbus)
TIMEOUT, 15, maximum ACCESS cycles without mfc before abort (range 2..255)

Ports:
clk  input  1  system clock, rising edge
rstIn  input  1  asynchronous active-low reset
cpu_req  input  1  CPU access request; held until cpu_done
cpu_we  input  1  1=write, 0=read
cpu_addr  input  AW  CPU address
cpu_wdata  input  DW  CPU write data
cpu_rdata  output  DW  read data, valid while cpu_done=1
cpu_done  output  1  one-cycle completion pulse
cpu_err  output  1  with cpu_done: access timed out
dma_req, dma_we, dma_addr, dma_wdata  inputs  1/1/AW/DW  same as CPU port
dma_rdata, dma_done, dma_err  outputs  DW/1/1  same as CPU port
mem_Abus  output  AW  memory address
mem_Dbus  inout  DW  memory data bus; driven only during a granted write
mem_rdM  output  1  memory read strobe
mem_wrM  output  1  memory write strobe
mem_mfc  input  1  memory function complete
grant  output  2  01=CPU, 10=DMA, 00=none; never 11
busy  output  1  1 in ACCESS or DONE

Behaviour:
- Reset (rstIn=0, async): state=IDLE; grant=00; busy, mem_rdM, mem_wrM, all done and err = 0; rdata regs, mem_Abus and counter = 0; mem_Dbus=Z; last_grant=DMA, so the CPU wins the first tie.
- Reset mid-access: strobes drop immediately and no done is issued; the requester re-requests.
- IDLE:
  - Grant only when mem_mfc=0. A stale mfc blocks new grants.
  - One requester: grant it.
  - Both requesting: grant the one not in last_grant (round-robin).
  - On the grant edge, latch we/addr/wdata into internal regs, clear the counter and go to ACCESS.
- ACCESS:
  - mem_Abus = latched addr.
  - mem_rdM = ~we, mem_wrM = we, both asserted from the first ACCESS cycle.
  - Write: mem_Dbus = latched wdata. Read: mem_Dbus = Z.
  - Requester inputs are ignored; dropping req mid-access does not cancel it.
  - mem_mfc=1 sampled: on a read, capture mem_Dbus into the granted rdata reg; go to DONE with err=0.
  - Counter reaches TIMEOUT-1 with mfc=0: go to DONE with err=1; rdata is left unchanged.
  - mfc takes priority over timeout in the same cycle.
- DONE (exactly 1 cycle):
  - Strobes = 0, mem_Dbus = Z.
  - The granted port's done=1, with err as determined.
  - last_grant = current grant.
  - Go to IDLE, where grant returns to 00.
- Latency: req high at edge N gives strobes during cycle N+1. With mfc on the first ACCESS cycle, done is high in cycle N+2. The minimum is 3 cycles per access, with one IDLE cycle between back-to-back accesses.
- A requester holding req through done issues a new access. Under contention, grants alternate strictly.
- rdata holds its last value between accesses.
- Grant is one-hot or zero, never both.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum {IDLE, ACCESS, DONE}
  - grant encodings GNT_NONE/GNT_CPU/GNT_DMA
  - default TIMEOUT
- Optional sub-module arb_rr2: 2-way round-robin pick from (req[1:0], last_grant) → grant. It is purely combinational; the main FSM stays in mem_bus_arbiter.

Test Plan:
- CPU read, addr 0x0010, memory returns 0xBEEF with mfc 1 cycle after rdM → mem_rdM high 1+ cycles, cpu_rdata=0xBEEF, cpu_done 1-cycle pulse, cpu_err=0, dma_done stays 0.
- DMA write, addr 0x0200, data 0x1234 → mem_wrM=1, mem_Dbus=0x1234, mem_Abus=0x0200 during ACCESS; Dbus=Z after DONE; dma_done pulse.
- cpu_req and dma_req both held high for 4 accesses from reset → grant sequence CPU, DMA, CPU, DMA.
- DMA read with mfc never asserted → after 15 ACCESS cycles dma_done=1 and dma_err=1, dma_rdata unchanged, strobes drop.
- rstIn pulled low mid-ACCESS of a CPU write → mem_wrM=0 and mem_Dbus=Z immediately; no cpu_done; first grant after release goes to CPU.
- mem_mfc held high in IDLE with cpu_req=1 → no grant until mfc falls; the access then starts on the next edge.
